// File: rtl/wb_port_arbiter_if.sv
// Writeback-port arbiter bus: ALU writeback, long-latency handshake, RF write port, decode hazard probe.
// slave is the arbiter side, master is the driving side.
interface wb_port_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             alu_we;
  logic [4:0]       alu_rd;
  logic [WIDTH-1:0] alu_data;
  logic             lu_valid;
  logic             lu_ready;
  logic [4:0]       lu_rd;
  logic [WIDTH-1:0] lu_data;
  logic             rf_we;
  logic [4:0]       rf_as3;
  logic [WIDTH-1:0] rf_wdata;
  logic             pipe_stall;
  logic [4:0]       chk_ad1;
  logic [4:0]       chk_ad2;
  logic             hz1;
  logic             hz2;

  modport slave (
    input  alu_we, alu_rd, alu_data, lu_valid, lu_rd, lu_data, chk_ad1, chk_ad2,
    output lu_ready, rf_we, rf_as3, rf_wdata, pipe_stall, hz1, hz2
  );

  modport master (
    output alu_we, alu_rd, alu_data, lu_valid, lu_rd, lu_data, chk_ad1, chk_ad2,
    input  lu_ready, rf_we, rf_as3, rf_wdata, pipe_stall, hz1, hz2
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the ALU pipe and a buffered long-latency source.
// Optional WB_PERF_EN adds saturating conflict_cnt / stall_cnt counters.
module wb_port_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  wb_port_arbiter_if.slave        bus
`ifdef WB_PERF_EN
  ,
  output logic [31:0]             conflict_cnt,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned AGE_W = $clog2(MAX_WAIT + 1);

  logic [WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
  logic [4:0]       fifo_rd_q   [FIFO_DEPTH];
  logic [4:0]       fifo_rd_d   [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_as3_q, rf_as3_d;
  logic [WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic             pipe_stall_q, pipe_stall_d;

  logic                  full, empty, push, pop, alu_win;
  logic [FIFO_DEPTH-1:0] entry_vld;
  logic                  hit1, hit2;

  // Handshake, arbitration and next state
  always_comb begin
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    empty    = (count_q == '0);
    push     = bus.lu_valid && !rst && !full && (bus.lu_rd != 5'd0);
    // ALU writes under a drain stall are a protocol violation and are dropped
    alu_win  = bus.alu_we && (bus.alu_rd != 5'd0) && !pipe_stall_q;
    pop      = !empty && !alu_win;

    fifo_data_d = fifo_data_q;
    fifo_rd_d   = fifo_rd_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = bus.lu_data;
      fifo_rd_d[wr_ptr_q]   = bus.lu_rd;
    end
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    if (empty || pop)                      age_d = '0;
    else if (age_q != AGE_W'(MAX_WAIT))    age_d = age_q + AGE_W'(1);
    else                                   age_d = age_q;
    pipe_stall_d = (age_d == AGE_W'(MAX_WAIT));

    rf_we_d    = alu_win || pop;
    rf_as3_d   = rf_as3_q;
    rf_wdata_d = rf_wdata_q;
    if (alu_win) begin
      rf_as3_d   = bus.alu_rd;
      rf_wdata_d = bus.alu_data;
    end else if (pop) begin
      rf_as3_d   = fifo_rd_q[rd_ptr_q];
      rf_wdata_d = fifo_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_rd_q[i]   <= '0;
      end
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      age_q        <= '0;
      rf_we_q      <= 1'b0;
      rf_as3_q     <= '0;
      rf_wdata_q   <= '0;
      pipe_stall_q <= 1'b0;
    end else begin
      fifo_data_q  <= fifo_data_d;
      fifo_rd_q    <= fifo_rd_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      age_q        <= age_d;
      rf_we_q      <= rf_we_d;
      rf_as3_q     <= rf_as3_d;
      rf_wdata_q   <= rf_wdata_d;
      pipe_stall_q <= pipe_stall_d;
    end
  end

  // Read-hazard probe against buffered entries and the write currently on the port
  always_comb begin
    entry_vld = '0;
    hit1      = 1'b0;
    hit2      = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      entry_vld[i] = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr_q)) < count_q;
      hit1 = hit1 || (entry_vld[i] && (fifo_rd_q[i] == bus.chk_ad1));
      hit2 = hit2 || (entry_vld[i] && (fifo_rd_q[i] == bus.chk_ad2));
    end
    bus.hz1 = (bus.chk_ad1 != 5'd0) && (hit1 || (rf_we_q && (rf_as3_q == bus.chk_ad1)));
    bus.hz2 = (bus.chk_ad2 != 5'd0) && (hit2 || (rf_we_q && (rf_as3_q == bus.chk_ad2)));
  end

  assign bus.lu_ready   = !rst && !full;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_as3     = rf_as3_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.pipe_stall = pipe_stall_q;

`ifdef WB_PERF_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (!empty && alu_win && (conflict_cnt_q != '1)) conflict_cnt_d = conflict_cnt_q + 32'd1;
    if (pipe_stall_q && (stall_cnt_q != '1))         stall_cnt_d    = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: ALU path, idle drain, starvation stall, full FIFO, x0, mid-op reset.
module tb_wb_port_arbiter;
  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  wb_port_arbiter_if #(.WIDTH(WIDTH)) bus ();

`ifdef WB_PERF_EN
  logic [31:0] conflict_cnt, stall_cnt;
`endif

  wb_port_arbiter #(.WIDTH(WIDTH), .FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef WB_PERF_EN
    ,
    .conflict_cnt (conflict_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) assert (!(bus.pipe_stall && bus.alu_we)) else $error("protocol: alu_we during pipe_stall");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic we, input logic [4:0] rd, input logic [31:0] data);
    bus.alu_we   = we;
    bus.alu_rd   = rd;
    bus.alu_data = data;
  endtask

  task automatic set_lu(input logic vld, input logic [4:0] rd, input logic [31:0] data);
    bus.lu_valid = vld;
    bus.lu_rd    = rd;
    bus.lu_data  = data;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    set_alu(1'b0, 5'd0, 32'd0);
    set_lu(1'b0, 5'd0, 32'd0);
    bus.chk_ad1 = 5'd0;
    bus.chk_ad2 = 5'd0;
    tick();
    tick();
    check_eq("rst_lu_ready", 32'(bus.lu_ready), 32'd0);
    check_eq("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check_eq("rst_rf_as3", 32'(bus.rf_as3), 32'd0);
    check_eq("rst_rf_wdata", bus.rf_wdata, 32'd0);
    check_eq("rst_stall", 32'(bus.pipe_stall), 32'd0);
    check_eq("rst_hz1", 32'(bus.hz1), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rel_lu_ready", 32'(bus.lu_ready), 32'd1);

    // ALU only
    set_alu(1'b1, 5'd5, 32'hDEADBEEF);
    bus.chk_ad1 = 5'd5;
    tick();
    check_eq("alu_we", 32'(bus.rf_we), 32'd1);
    check_eq("alu_as3", 32'(bus.rf_as3), 32'd5);
    check_eq("alu_wdata", bus.rf_wdata, 32'hDEADBEEF);
    check_eq("alu_hz1_port", 32'(bus.hz1), 32'd1);
    set_alu(1'b1, 5'd0, 32'h12345678);
    tick();
    check_eq("alu_x0_we", 32'(bus.rf_we), 32'd0);
    check_eq("alu_x0_hold_as3", 32'(bus.rf_as3), 32'd5);
    check_eq("alu_x0_hold_wdata", bus.rf_wdata, 32'hDEADBEEF);
    check_eq("alu_x0_hz1", 32'(bus.hz1), 32'd0);
    set_alu(1'b0, 5'd0, 32'd0);

    // Idle-port drain, in order
    set_lu(1'b1, 5'd7, 32'h11);
    tick();
    check_eq("drain_ready1", 32'(bus.lu_ready), 32'd1);
    check_eq("drain_no_bypass", 32'(bus.rf_we), 32'd0);
    set_lu(1'b1, 5'd8, 32'h22);
    tick();
    check_eq("drain_we7", 32'(bus.rf_we), 32'd1);
    check_eq("drain_as3_7", 32'(bus.rf_as3), 32'd7);
    check_eq("drain_data_7", bus.rf_wdata, 32'h11);
    check_eq("drain_ready2", 32'(bus.lu_ready), 32'd1);
    set_lu(1'b0, 5'd0, 32'd0);
    tick();
    check_eq("drain_as3_8", 32'(bus.rf_as3), 32'd8);
    check_eq("drain_data_8", bus.rf_wdata, 32'h22);
    tick();
    check_eq("drain_idle_we", 32'(bus.rf_we), 32'd0);

    // Full FIFO with ALU busy
    set_alu(1'b1, 5'd1, 32'hA0);
    set_lu(1'b1, 5'd10, 32'hA);
    tick();
    set_lu(1'b1, 5'd11, 32'hB);
    check_eq("full_ready_one", 32'(bus.lu_ready), 32'd1);
    tick();
    check_eq("full_ready0", 32'(bus.lu_ready), 32'd0);
    check_eq("full_alu_as3", 32'(bus.rf_as3), 32'd1);
    bus.chk_ad1 = 5'd11;
    bus.chk_ad2 = 5'd12;
    set_lu(1'b1, 5'd12, 32'hC);
    #1;
    check_eq("full_hz1", 32'(bus.hz1), 32'd1);
    check_eq("full_hz2", 32'(bus.hz2), 32'd0);
    tick();
    check_eq("full_ready0_b", 32'(bus.lu_ready), 32'd0);
    set_alu(1'b0, 5'd0, 32'd0);
    tick();
    check_eq("full_pop_as3_10", 32'(bus.rf_as3), 32'd10);
    check_eq("full_pop_data_10", bus.rf_wdata, 32'hA);
    check_eq("full_ready_after_pop", 32'(bus.lu_ready), 32'd1);
    tick();
    check_eq("full_pop_as3_11", 32'(bus.rf_as3), 32'd11);
    set_lu(1'b0, 5'd0, 32'd0);
    tick();
    check_eq("full_pop_as3_12", 32'(bus.rf_as3), 32'd12);
    check_eq("full_pop_data_12", bus.rf_wdata, 32'hC);
    tick();
    check_eq("full_idle_we", 32'(bus.rf_we), 32'd0);
    check_eq("full_no_stall", 32'(bus.pipe_stall), 32'd0);

    // Starvation: head rd=9 loses to the ALU four times
    bus.chk_ad1 = 5'd9;
    bus.chk_ad2 = 5'd0;
    set_alu(1'b1, 5'd2, 32'h100);
    set_lu(1'b1, 5'd9, 32'h99);
    tick();
    set_lu(1'b0, 5'd0, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("starve_stall0_%0d", k), 32'(bus.pipe_stall), 32'd0);
      check_eq($sformatf("starve_hz1_%0d", k), 32'(bus.hz1), 32'd1);
      tick();
    end
    check_eq("starve_stall1", 32'(bus.pipe_stall), 32'd1);
    check_eq("starve_alu_as3", 32'(bus.rf_as3), 32'd2);
    check_eq("starve_hz2_x0", 32'(bus.hz2), 32'd0);
    set_alu(1'b0, 5'd0, 32'd0);
    tick();
    check_eq("starve_pop_as3", 32'(bus.rf_as3), 32'd9);
    check_eq("starve_pop_data", bus.rf_wdata, 32'h99);
    check_eq("starve_stall_drop", 32'(bus.pipe_stall), 32'd0);
    tick();
    check_eq("starve_idle_we", 32'(bus.rf_we), 32'd0);
    check_eq("starve_hz1_clear", 32'(bus.hz1), 32'd0);

    // x0 push accepted but discarded; pending rd=3 hazard
    set_alu(1'b1, 5'd4, 32'h44);
    set_lu(1'b1, 5'd3, 32'h33);
    tick();
    bus.chk_ad1 = 5'd3;
    bus.chk_ad2 = 5'd0;
    set_lu(1'b1, 5'd0, 32'h55);
    #1;
    check_eq("x0_hz1", 32'(bus.hz1), 32'd1);
    check_eq("x0_hz2", 32'(bus.hz2), 32'd0);
    check_eq("x0_ready", 32'(bus.lu_ready), 32'd1);
    tick();
    check_eq("x0_not_full", 32'(bus.lu_ready), 32'd1);
    set_alu(1'b0, 5'd0, 32'd0);
    set_lu(1'b0, 5'd0, 32'd0);
    tick();
    check_eq("x0_pop_as3_3", 32'(bus.rf_as3), 32'd3);
    check_eq("x0_pop_data", bus.rf_wdata, 32'h33);
    tick();
    check_eq("x0_never_written", 32'(bus.rf_we), 32'd0);

    // Reset mid-operation with two entries held and stall raised
    set_alu(1'b1, 5'd1, 32'h1);
    set_lu(1'b1, 5'd20, 32'h20);
    tick();
    set_lu(1'b1, 5'd21, 32'h21);
    tick();
    set_lu(1'b0, 5'd0, 32'd0);
    n = 0;
    while (!bus.pipe_stall && n < 8) begin
      tick();
      n++;
    end
    if (bus.pipe_stall) set_alu(1'b0, 5'd0, 32'd0);
    check_eq("mid_stall_cycles", 32'(n), 32'd3);
    check_eq("mid_stall_up", 32'(bus.pipe_stall), 32'd1);
    check_eq("mid_full", 32'(bus.lu_ready), 32'd0);
    set_alu(1'b0, 5'd0, 32'd0);
    bus.chk_ad1 = 5'd20;
    bus.chk_ad2 = 5'd21;
    rst = 1'b1;
    tick();
    check_eq("mid_rst_we", 32'(bus.rf_we), 32'd0);
    check_eq("mid_rst_as3", 32'(bus.rf_as3), 32'd0);
    check_eq("mid_rst_wdata", bus.rf_wdata, 32'd0);
    check_eq("mid_rst_stall", 32'(bus.pipe_stall), 32'd0);
    check_eq("mid_rst_ready", 32'(bus.lu_ready), 32'd0);
    check_eq("mid_rst_hz1", 32'(bus.hz1), 32'd0);
    check_eq("mid_rst_hz2", 32'(bus.hz2), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("mid_rel_ready", 32'(bus.lu_ready), 32'd1);
    tick();
    check_eq("mid_post_we_a", 32'(bus.rf_we), 32'd0);
    tick();
    check_eq("mid_post_we_b", 32'(bus.rf_we), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
